// File: rtl/alu_control_unit.sv
// ---------------------------------------------------------------------------
// alu_control_unit
//
// Purpose:
//   Sequencer that sits between an instruction source and a combinational
//   ALU. It accepts one 32-bit instruction over a valid/ready handshake,
//   reads its operands from an internal register file, presents operands
//   and opcode to the ALU, allows one settle cycle, then writes the ALU
//   result back and updates the C/Z/N status flags. Only one instruction
//   is in flight at a time.
//
// Instruction format:
//   [31:26] op   [25:23] rd   [22:20] rs1   [19:17] rs2
//   [16]    use_imm           [15:0]  imm (zero-extended)
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   instr_valid    instruction available
//   instr          32-bit instruction word
//   instr_ready    CU can accept an instruction (IDLE only)
//   alu_a, alu_b   ALU operands (R[rs1], imm or R[rs2])
//   alu_op         ALU opcode, 0 = no-op
//   alu_ans1       ALU result
//   alu_ans2       ALU carry/borrow
//   alu_z, alu_n   ALU zero / negative flags
//   done           one-cycle pulse when an instruction retires
//   err            one-cycle pulse with done for an illegal opcode
//   flag_c/z/n     status flags
//   dbg_addr       register read-back address
//   dbg_data       R[dbg_addr], combinational; 0 for r0 and out-of-range
//
// States:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for instr_valid; instr_ready high
//   S_DECODE | check opcode, read register file, register ALU inputs
//   S_EXEC   | ALU settle cycle, operands/opcode held stable
//   S_WB     | done (and err) high; result and flags written on exit
// ---------------------------------------------------------------------------
module alu_control_unit #(
  parameter int NREG  = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] alu_ans1,
  input  logic             alu_ans2,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             done,
  output logic             err,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int         AW     = $clog2(NREG);
  localparam logic [3:0] NREG_L = 4'(NREG);

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_SLL = 6'b110000;
  localparam logic [5:0] OP_SRL = 6'b110001;
  localparam logic [5:0] OP_SRA = 6'b110010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      instr_q;
  logic             illegal_q;
  logic [WIDTH-1:0] regs [NREG];

  logic [5:0]  q_op;
  logic [2:0]  q_rd;
  logic [2:0]  q_rs1;
  logic [2:0]  q_rs2;
  logic        q_use_imm;
  logic [15:0] q_imm;

  assign q_op      = instr_q[31:26];
  assign q_rd      = instr_q[25:23];
  assign q_rs1     = instr_q[22:20];
  assign q_rs2     = instr_q[19:17];
  assign q_use_imm = instr_q[16];
  assign q_imm     = instr_q[15:0];

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB,
      OP_EQ, OP_NE, OP_LE, OP_GT,
      OP_SLL, OP_SRL, OP_SRA: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // r0 is hardwired to zero; addresses beyond the implemented file read 0
  // so a smaller NREG never aliases onto a lower register.
  function automatic logic addr_live(input logic [2:0] a);
    return (a != 3'd0) && ({1'b0, a} < NREG_L);
  endfunction

  function automatic logic [WIDTH-1:0] reg_read(input logic [2:0] a);
    if (!addr_live(a)) return '0;
    return regs[a[AW-1:0]];
  endfunction

  assign dbg_data = reg_read(dbg_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      illegal_q   <= 1'b0;
      instr_ready <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end
        end

        S_DECODE: begin
          // Illegal ops still pass through EXEC so every instruction
          // retires with the same latency; the ALU only ever sees op 0.
          if (op_legal(q_op)) begin
            illegal_q <= 1'b0;
            alu_a     <= reg_read(q_rs1);
            alu_b     <= q_use_imm ? {{(WIDTH-16){1'b0}}, q_imm}
                                   : reg_read(q_rs2);
            alu_op    <= q_op;
          end else begin
            illegal_q <= 1'b1;
          end
          state <= S_EXEC;
        end

        S_EXEC: begin
          done  <= 1'b1;
          err   <= illegal_q;
          state <= S_WB;
        end

        S_WB: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (!illegal_q) begin
            if (addr_live(q_rd)) begin
              regs[q_rd[AW-1:0]] <= alu_ans1;
            end
            flag_z <= alu_z;
            flag_n <= alu_n;
            // Carry is only meaningful for arithmetic ops.
            if (q_op == OP_ADD || q_op == OP_SUB) begin
              flag_c <= alu_ans2;
            end
          end
          alu_a       <= '0;
          alu_b       <= '0;
          alu_op      <= '0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
